audio_mix_sequencer: RTL and testbench

//  Control sequencer for the audio mixer datapath. Generates the mixer sample strobe.

---
 rtl/audio_mix_sequencer_if.sv | 22 ++
 rtl/audio_mix_sequencer.sv | 147 ++++++++++++++
 tb/tb_audio_mix_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/audio_mix_sequencer_if.sv
// Config request handshake and mixer control bundle
// for the audio mix sequencer.
interface audio_mix_sequencer_if;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [4:0] cfg_att;
   logic [1:0] cfg_mix;
   logic       mix_ce;
   logic [4:0] mix_att;
   logic [1:0] mix_mix;
   logic       busy;

   modport master (
      output cfg_valid, cfg_att, cfg_mix,
      input  cfg_ready, mix_ce, mix_att, mix_mix, busy
   );

   modport slave (
      input  cfg_valid, cfg_att, cfg_mix,
      output cfg_ready, mix_ce, mix_att, mix_mix, busy
   );
endinterface

// File: rtl/audio_mix_sequencer.sv
// Mixer sample strobe plus click-free attenuation ramp
// and mute-guarded mix-mode switching.
module audio_mix_sequencer #(
   parameter int CE_DIV    = 4,
   parameter int RAMP_DIV  = 2,
   parameter int MUTE_HOLD = 3
) (
   input logic                  clk,
   input logic                  reset_n,
   audio_mix_sequencer_if.slave cfg
);

   localparam int CW = $clog2(CE_DIV);
   localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int HW = (MUTE_HOLD > 1) ? $clog2(MUTE_HOLD) : 1;
   localparam logic [CW-1:0] CE_LAST   = CW'(CE_DIV - 1);
   localparam logic [RW-1:0] STEP_LAST = RW'(RAMP_DIV - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(MUTE_HOLD - 1);
   localparam logic [4:0]    MUTE      = 5'd16;

   typedef enum logic [1:0] {
      IDLE,
      FADE_OUT,
      HOLD,
      RAMP
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] ce_cnt;
   logic          ce;
   logic [4:0]    level, level_n;
   logic [4:0]    tgt_level, tgt_level_n;
   logic [4:0]    req_level;
   logic [4:0]    att_q;
   logic [1:0]    mix_q, mix_n;
   logic [1:0]    tgt_mix, tgt_mix_n;
   logic [RW-1:0] step_cnt, step_n;
   logic [HW-1:0] hold_cnt, hold_n;
   logic          tick;

   assign req_level = cfg.cfg_att[4] ? MUTE
                    : {1'b0, cfg.cfg_att[3:0]};
   assign tick      = ce && (step_cnt == STEP_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ce_cnt <= '0;
         ce     <= 1'b0;
      end else begin
         ce_cnt <= (ce_cnt == CE_LAST) ? '0 : ce_cnt + 1'b1;
         ce     <= (ce_cnt == CE_LAST);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         level     <= MUTE;
         att_q     <= MUTE;
         mix_q     <= 2'd0;
         tgt_level <= MUTE;
         tgt_mix   <= 2'd0;
         step_cnt  <= '0;
         hold_cnt  <= '0;
      end else begin
         state     <= state_n;
         level     <= level_n;
         mix_q     <= mix_n;
         tgt_level <= tgt_level_n;
         tgt_mix   <= tgt_mix_n;
         step_cnt  <= step_n;
         hold_cnt  <= hold_n;
         // level only moves on a tick, so att follows on the ce edge
         att_q     <= (level_n == MUTE) ? MUTE
                    : {1'b0, level_n[3:0]};
      end
   end

   always_comb begin
      state_n     = state;
      level_n     = level;
      mix_n       = mix_q;
      tgt_level_n = tgt_level;
      tgt_mix_n   = tgt_mix;
      step_n      = step_cnt;
      hold_n      = hold_cnt;
      if (ce && (state == FADE_OUT || state == RAMP)) begin
         step_n = tick ? '0 : step_cnt + 1'b1;
      end
      unique case (state)
         IDLE: begin
            if (cfg.cfg_valid) begin
               tgt_level_n = req_level;
               tgt_mix_n   = cfg.cfg_mix;
               step_n      = '0;
               if (cfg.cfg_mix != mix_q) begin
                  state_n = FADE_OUT;
               end else if (req_level != level) begin
                  state_n = RAMP;
               end
            end
         end
         FADE_OUT: begin
            if (level == MUTE) begin
               state_n = HOLD;
               hold_n  = '0;
            end else if (tick) begin
               level_n = level + 5'd1;
               if (level_n == MUTE) begin
                  state_n = HOLD;
                  hold_n  = '0;
               end
            end
         end
         HOLD: begin
            if (ce) begin
               if (hold_cnt == HOLD_LAST) begin
                  mix_n   = tgt_mix;
                  state_n = RAMP;
                  step_n  = '0;
               end else begin
                  hold_n = hold_cnt + 1'b1;
               end
            end
         end
         RAMP: begin
            if (level == tgt_level) begin
               state_n = IDLE;
            end else if (tick) begin
               level_n = (level < tgt_level) ? level + 5'd1
                       : level - 5'd1;
               if (level_n == tgt_level) begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign cfg.cfg_ready = (state == IDLE);
   assign cfg.busy      = (state != IDLE);
   assign cfg.mix_ce    = ce;
   assign cfg.mix_att   = att_q;
   assign cfg.mix_mix   = mix_q;

endmodule

// File: tb/tb_audio_mix_sequencer.sv
// Random and directed requests against a per-strobe
// plan model of the attenuation/mix trajectory.
module tb_audio_mix_sequencer;

   localparam int CE_DIV    = 4;
   localparam int RAMP_DIV  = 2;
   localparam int MUTE_HOLD = 3;

   typedef struct packed {
      logic [4:0] lvl;
      logic [1:0] mix;
   } step_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   audio_mix_sequencer_if bus ();

   audio_mix_sequencer #(
      .CE_DIV   (CE_DIV),
      .RAMP_DIV (RAMP_DIV),
      .MUTE_HOLD(MUTE_HOLD)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .cfg    (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   step_t      plan[$];
   logic [4:0] exp_att;
   logic [1:0] exp_mix;
   logic       exp_busy;
   logic       exp_ce;
   int         edges;
   int         age;
   bit         hold_lead;
   int         tail;
   bit         acc;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h @%0t",
                  tag, got, want, $time);
      end
   endtask

   function automatic step_t mk(input int l, input logic [1:0] m);
      step_t s;
      s.lvl = 5'(l);
      s.mix = m;
      return s;
   endfunction

   task automatic model_reset();
      plan.delete();
      exp_att   = 5'h10;
      exp_mix   = 2'd0;
      exp_busy  = 1'b0;
      exp_ce    = 1'b0;
      edges     = 0;
      age       = 0;
      hold_lead = 1'b0;
      tail      = 0;
   endtask

   // one entry per future mix_ce: outputs after that strobe
   task automatic build_plan(input logic [4:0] att,
                             input logic [1:0] mix);
      int l, t;
      logic [1:0] m;
      l = int'(exp_att);
      m = exp_mix;
      t = att[4] ? 16 : int'(att[3:0]);
      hold_lead = 1'b0;
      tail = 0;
      if (mix != m) begin
         if (l == 16) hold_lead = 1'b1;
         while (l < 16) begin
            for (int k = 0; k < RAMP_DIV - 1; k++)
               plan.push_back(mk(l, m));
            l++;
            plan.push_back(mk(l, m));
         end
         for (int k = 0; k < MUTE_HOLD - 1; k++)
            plan.push_back(mk(16, m));
         plan.push_back(mk(16, mix));
         m = mix;
         if (t == 16) tail = 1;
      end
      while (l != t) begin
         for (int k = 0; k < RAMP_DIV - 1; k++)
            plan.push_back(mk(l, m));
         l += (l < t) ? 1 : -1;
         plan.push_back(mk(l, m));
      end
   endtask

   task automatic cyc();
      step_t s;
      logic busy_b;
      @(posedge clk);
      #1;
      acc = 1'b0;
      if (!reset_n) begin
         model_reset();
      end else begin
         edges++;
         age++;
         busy_b = exp_busy;
         if (busy_b) begin
            if (plan.size() > 0) begin
               if (exp_ce && !(hold_lead && age == 1)) begin
                  s = plan.pop_front();
                  exp_att = s.lvl;
                  exp_mix = s.mix;
                  if (plan.size() == 0 && tail == 0)
                     exp_busy = 1'b0;
               end
            end else begin
               exp_busy = 1'b0;
            end
         end else if (bus.cfg_valid) begin
            acc = 1'b1;
            build_plan(bus.cfg_att, bus.cfg_mix);
            age = 0;
            exp_busy = (plan.size() > 0);
         end
         exp_ce = ((edges % CE_DIV) == 0);
      end
      chk("mix_ce", bus.mix_ce, exp_ce);
      chk("mix_att", bus.mix_att, exp_att);
      chk("mix_mix", bus.mix_mix, exp_mix);
      chk("busy", bus.busy, exp_busy);
      chk("cfg_ready", bus.cfg_ready, !exp_busy);
   endtask

   task automatic req(input logic [4:0] att,
                      input logic [1:0] mix);
      bus.cfg_valid = 1'b1;
      bus.cfg_att   = att;
      bus.cfg_mix   = mix;
      acc = 1'b0;
      for (int i = 0; i < 2000 && !acc; i++) cyc();
      chk("accept_wait", acc, 1'b1);
      bus.cfg_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 2000 && exp_busy; i++) cyc();
      chk("idle_wait", bus.busy, 1'b0);
   endtask

   initial begin
      logic [4:0] ra;
      logic [1:0] rm;
      bus.cfg_valid = 1'b0;
      bus.cfg_att   = 5'd0;
      bus.cfg_mix   = 2'd0;
      model_reset();
      repeat (3) cyc();
      reset_n = 1'b1;

      repeat (40) cyc();
      chk("t1_att", bus.mix_att, 5'h10);
      chk("t1_ready", bus.cfg_ready, 1'b1);

      req(5'h00, 2'd0);
      wait_idle();
      chk("t2_att", bus.mix_att, 5'h00);

      req(5'h02, 2'd3);
      wait_idle();
      chk("t3_att", bus.mix_att, 5'h02);
      chk("t3_mix", bus.mix_mix, 2'd3);

      req(5'h02, 2'd3);
      cyc();
      chk("t4_busy", bus.busy, 1'b0);

      req(5'h02, 2'd1);
      req(5'h05, 2'd1);
      wait_idle();
      chk("t5_att", bus.mix_att, 5'h05);
      chk("t5_mix", bus.mix_mix, 2'd1);

      req(5'h13, 2'd1);
      wait_idle();
      chk("t6_att", bus.mix_att, 5'h10);
      req(5'h00, 2'd2);
      repeat (50) cyc();
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_att", bus.mix_att, 5'h10);
      chk("rst_mix", bus.mix_mix, 2'd0);
      chk("rst_ce", bus.mix_ce, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_ready", bus.cfg_ready, 1'b1);
      model_reset();
      repeat (2) cyc();
      reset_n = 1'b1;

      for (int it = 0; it < 40; it++) begin
         ra = 5'($urandom_range(0, 31));
         rm = ($urandom_range(0, 2) == 0)
            ? 2'($urandom_range(0, 3)) : exp_mix;
         req(ra, rm);
         if ($urandom_range(0, 3) != 0) wait_idle();
         repeat ($urandom_range(0, 6)) cyc();
      end
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
